// File: rtl/spectrum_bar_engine.sv
// Frame-synchronous spectrum bar engine: walks FFT bins, bins them into log-spaced bars, applies
// EMA smoothing and publishes through a double buffer. Optional peak hold: SPECTRUM_PEAK_HOLD_EN.
module spectrum_bar_engine #(
  parameter int unsigned GFX_WIDTH         = 6,
  parameter int unsigned NUM_SAMPLES       = 101,
  parameter int unsigned BARS              = 16,
  parameter int unsigned FIRST_BIN         = 2,
  parameter int unsigned LINEAR_BARS       = 7,
  parameter int unsigned MAX_HEIGHT        = 30,
  parameter int unsigned PEAK_DECAY_FRAMES = 4
) (
  input  logic                                  clk_25MHz,
  input  logic                                  rst,
  input  logic                                  vsync,
  input  logic [1:0]                            ema_alpha,
  input  logic [NUM_SAMPLES-1:0][GFX_WIDTH-1:0] freq_scaled,
  input  logic [$clog2(BARS+1)-1:0]             bar_sel,
  output logic [GFX_WIDTH-1:0]                  bar_height,
  output logic [GFX_WIDTH-1:0]                  peak_height,
  output logic                                  busy,
  output logic                                  frame_done,
  output logic                                  overrun
);

  function automatic int unsigned group_log2(input int unsigned b);
    return (b < LINEAR_BARS) ? 0 : 1 + (b - LINEAR_BARS) / 2;
  endfunction

  function automatic int unsigned total_bins();
    int unsigned t;
    t = 0;
    for (int unsigned b = 0; b < BARS; b++) t += 1 << group_log2(b);
    return t;
  endfunction

  localparam int unsigned MaxLog2 = group_log2(BARS - 1);
  localparam int unsigned AccW    = GFX_WIDTH + MaxLog2;
  localparam int unsigned BinW    = $clog2(FIRST_BIN + total_bins() + 1);
  localparam int unsigned BarW    = $clog2(BARS);
  localparam int unsigned CntW    = MaxLog2 + 1;
  // Wide enough for work * 7 at alpha=3, so the product never wraps.
  localparam int unsigned ProdW   = GFX_WIDTH + 3;

  if (BARS < 2 || PEAK_DECAY_FRAMES < 1) begin : g_param_check
    $error("spectrum_bar_engine: BARS must be >= 2 and PEAK_DECAY_FRAMES >= 1");
  end

  typedef enum logic [1:0] {StIdle, StAccum, StEma, StCommit} state_e;

  state_e              state_q;
  logic [1:0]          vs_sr_q;
  logic [1:0]          alpha_q;
  logic [AccW-1:0]     acc_q;
  logic [BarW-1:0]     bar_q;
  logic [BinW-1:0]     bin_q;
  logic [CntW-1:0]     cnt_q;
  logic [GFX_WIDTH-1:0] work_q [BARS];
  logic [GFX_WIDTH-1:0] disp_q [BARS];

  logic                 start;
  logic [GFX_WIDTH-1:0] bin_val;
  logic [31:0]          cur_lg;
  logic                 cur_last;
  logic [GFX_WIDTH-1:0] avg;
  logic [ProdW-1:0]     ema_mask;
  logic [ProdW-1:0]     ema_prod;
  logic [GFX_WIDTH-1:0] ema_new;
  logic [GFX_WIDTH-1:0] clamp [BARS];

  assign start = (vs_sr_q == 2'b01);

  always_comb begin
    bin_val = '0;
    for (int i = 0; i < NUM_SAMPLES; i++) begin
      if (32'(bin_q) == 32'(i)) bin_val = freq_scaled[i];
    end
    cur_lg   = (32'(bar_q) < LINEAR_BARS) ? 32'd0 : 32'd1 + ((32'(bar_q) - LINEAR_BARS) >> 1);
    cur_last = (32'(cnt_q) == ((32'd1 << cur_lg) - 32'd1));
    avg      = GFX_WIDTH'(acc_q >> cur_lg);
    ema_mask = (ProdW'(1) << alpha_q) - ProdW'(1);
    ema_prod = ProdW'(work_q[bar_q]) * ema_mask;
    ema_new  = (avg >> alpha_q) + GFX_WIDTH'(ema_prod >> alpha_q);
    for (int i = 0; i < BARS; i++) begin
      clamp[i] = (work_q[i] > GFX_WIDTH'(MAX_HEIGHT)) ? GFX_WIDTH'(MAX_HEIGHT) : work_q[i];
    end
  end

`ifdef SPECTRUM_PEAK_HOLD_EN
  localparam int unsigned FrmW = $clog2(PEAK_DECAY_FRAMES + 1);
  logic [GFX_WIDTH-1:0] peak_q [BARS];
  logic [FrmW-1:0]      frame_cnt_q;
  logic                 decay;
  assign decay = (32'(frame_cnt_q) == PEAK_DECAY_FRAMES - 1);
`endif

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      state_q    <= StIdle;
      vs_sr_q    <= '0;
      alpha_q    <= '0;
      acc_q      <= '0;
      bar_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < BARS; i++) begin
        work_q[i] <= '0;
        disp_q[i] <= '0;
      end
`ifdef SPECTRUM_PEAK_HOLD_EN
      frame_cnt_q <= '0;
      for (int i = 0; i < BARS; i++) peak_q[i] <= '0;
`endif
    end else begin
      vs_sr_q    <= {vs_sr_q[0], vsync};
      frame_done <= 1'b0;
      if (start && busy) overrun <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            alpha_q <= ema_alpha;
            acc_q   <= '0;
            bar_q   <= '0;
            bin_q   <= BinW'(FIRST_BIN);
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StAccum;
          end
        end
        StAccum: begin
          acc_q <= acc_q + AccW'(bin_val);
          bin_q <= bin_q + BinW'(1);
          if (cur_last) begin
            cnt_q   <= '0;
            state_q <= StEma;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StEma: begin
          work_q[bar_q] <= ema_new;
          acc_q         <= '0;
          if (bar_q == BarW'(BARS - 1)) begin
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state_q    <= StCommit;
          end else begin
            bar_q   <= bar_q + BarW'(1);
            state_q <= StAccum;
          end
        end
        StCommit: begin
          for (int i = 0; i < BARS; i++) disp_q[i] <= clamp[i];
`ifdef SPECTRUM_PEAK_HOLD_EN
          frame_cnt_q <= decay ? '0 : frame_cnt_q + FrmW'(1);
          for (int i = 0; i < BARS; i++) begin
            if (clamp[i] >= peak_q[i]) peak_q[i] <= clamp[i];
            else if (decay)            peak_q[i] <= peak_q[i] - GFX_WIDTH'(1);
          end
`endif
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Out-of-range selects read as zero.
  always_comb begin
    bar_height  = '0;
    peak_height = '0;
    if (32'(bar_sel) < BARS) begin
      bar_height = disp_q[bar_sel[BarW-1:0]];
`ifdef SPECTRUM_PEAK_HOLD_EN
      peak_height = peak_q[bar_sel[BarW-1:0]];
`endif
    end
  end

endmodule

// File: tb/tb_spectrum_bar_engine.sv
// Self-checking bench for spectrum_bar_engine: directed frames plus randomized frames checked
// against an arithmetic model of the bar grouping, EMA, clamp and peak-hold rules.
module tb_spectrum_bar_engine;

  logic              clk = 1'b0;
  logic              rst;
  logic              vsync;
  logic [1:0]        ema_alpha;
  logic [100:0][5:0] freq_scaled;
  logic [4:0]        bar_sel;
  logic [5:0]        bar_height;
  logic [5:0]        peak_height;
  logic              busy;
  logic              frame_done;
  logic              overrun;

  int pass_cnt = 0;
  int total_cnt = 0;

  int bins_m [101];
  int m_work [16];
  int m_disp [16];
  int m_peak [16];
  int m_frames;

  always #20 clk = ~clk;

  spectrum_bar_engine dut (
    .clk_25MHz  (clk),
    .rst        (rst),
    .vsync      (vsync),
    .ema_alpha  (ema_alpha),
    .freq_scaled(freq_scaled),
    .bar_sel    (bar_sel),
    .bar_height (bar_height),
    .peak_height(peak_height),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_work[i] = 0;
      m_disp[i] = 0;
      m_peak[i] = 0;
    end
    m_frames = 0;
  endtask

  // Bars 0..6: one bin; then 2,2,4,4,8,8,16,16,32 from bin 2; divide by nominal size.
  task automatic model_frame(input int alpha);
    int pos, size, sum, avg, a2;
    pos = 2;
    a2  = 1 << alpha;
    for (int b = 0; b < 16; b++) begin
      size = (b < 7) ? 1 : 2 ** (1 + (b - 7) / 2);
      sum  = 0;
      for (int j = pos; j < pos + size; j++) if (j < 101) sum += bins_m[j];
      avg       = sum / size;
      m_work[b] = avg / a2 + (m_work[b] * (a2 - 1)) / a2;
      pos += size;
    end
    m_frames++;
    for (int b = 0; b < 16; b++) begin
      m_disp[b] = (m_work[b] > 30) ? 30 : m_work[b];
      if (m_disp[b] >= m_peak[b])  m_peak[b] = m_disp[b];
      else if (m_frames % 4 == 0)  m_peak[b] = m_peak[b] - 1;
    end
  endtask

  function automatic int exp_peak(input int s);
`ifdef SPECTRUM_PEAK_HOLD_EN
    return (s < 16) ? m_peak[s] : 0;
`else
    return 0;
`endif
  endfunction

  task automatic apply_bins();
    for (int i = 0; i < 101; i++) freq_scaled[i] = 6'(bins_m[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  // Pulse vsync, then measure busy length, start-to-done latency and number of frame_done pulses.
  task automatic run_walk(output int busy_cyc, output int latency, output int done_cnt,
                          output bit timed_out);
    int n, first_busy;
    busy_cyc = 0; latency = 0; done_cnt = 0; timed_out = 1'b0; first_busy = -1; n = 0;
    vsync = 1'b1;
    while (done_cnt == 0 && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 3) vsync = 1'b0;
      if (busy) begin
        busy_cyc++;
        if (first_busy < 0) first_busy = n;
      end
      if (frame_done) begin
        done_cnt++;
        latency = n - first_busy + 1;
      end
    end
    vsync = 1'b0;
    if (done_cnt == 0) timed_out = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (frame_done) done_cnt++;
      if (busy) busy_cyc++;
    end
  endtask

  task automatic test_reset();
    int bc, lat, dc;
    bit to;
    vsync = 1'b0; ema_alpha = 2'd2; bar_sel = '0;
    for (int i = 0; i < 101; i++) bins_m[i] = 24;
    apply_bins();
    do_reset();
    vsync = 1'b1;
    repeat (60) @(negedge clk);
    vsync = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0)
      $display("FAIL reset_flags busy=%b done=%b ovr=%b required 000", busy, frame_done, overrun);
    else pass_cnt++;
    rst = 1'b0;
    model_reset();
    for (int s = 0; s < 32; s++) begin
      bar_sel = 5'(s);
      #1;
      total_cnt++;
      if (bar_height !== 6'd0 || peak_height !== 6'd0)
        $display("FAIL reset_read sel=%0d bar=%0d peak=%0d required 0", s, bar_height, peak_height);
      else pass_cnt++;
    end
    @(negedge clk);
    run_walk(bc, lat, dc, to);
    model_frame(2);
    total_cnt++;
    if (to || dc !== 1) $display("FAIL reset_restart done_pulses=%0d required 1", dc);
    else pass_cnt++;
    for (int s = 0; s < 16; s++) begin
      bar_sel = 5'(s);
      #1;
      total_cnt++;
      if (bar_height !== 6'(m_disp[s]))
        $display("FAIL reset_clean_walk sel=%0d got=%0d required=%0d", s, bar_height, m_disp[s]);
      else pass_cnt++;
    end
  endtask

  task automatic test_flat();
    int bc, lat, dc;
    bit to;
    ema_alpha = 2'd0;
    for (int i = 0; i < 101; i++) bins_m[i] = 20;
    apply_bins();
    do_reset();
    run_walk(bc, lat, dc, to);
    total_cnt++;
    if (to) $display("FAIL flat_timeout no frame_done within bound");
    else pass_cnt++;
    total_cnt++;
    if (bc !== 115) $display("FAIL flat_busy_len got=%0d required=115", bc);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 116) $display("FAIL flat_latency got=%0d required=116", lat);
    else pass_cnt++;
    for (int s = 0; s < 16; s++) begin
      bar_sel = 5'(s);
      #1;
      total_cnt++;
      if (bar_height !== 6'd20) $display("FAIL flat_bar sel=%0d got=%0d required=20", s, bar_height);
      else pass_cnt++;
    end
  endtask

  task automatic test_ema();
    int bc, lat, dc;
    bit to;
    int exp_h [3];
    exp_h = '{6, 10, 13};
    ema_alpha = 2'd2;
    for (int i = 0; i < 101; i++) bins_m[i] = 24;
    apply_bins();
    do_reset();
    for (int f = 0; f < 3; f++) begin
      run_walk(bc, lat, dc, to);
      if (f == 0) ema_alpha = 2'd0;
      for (int s = 0; s < 16; s += 5) begin
        bar_sel = 5'(s);
        #1;
        total_cnt++;
        if (bar_height !== 6'(exp_h[f]))
          $display("FAIL ema_frame%0d sel=%0d got=%0d required=%0d", f + 1, s, bar_height, exp_h[f]);
        else pass_cnt++;
      end
      ema_alpha = 2'd2;
    end
  endtask

  task automatic test_clamp();
    int bc, lat, dc;
    bit to;
    int e;
    ema_alpha = 2'd0;
    for (int i = 0; i < 101; i++) bins_m[i] = (i >= 69) ? 40 : 0;
    apply_bins();
    do_reset();
    run_walk(bc, lat, dc, to);
    for (int s = 0; s < 32; s++) begin
      bar_sel = 5'(s);
      #1;
      e = (s == 15) ? 30 : 0;
      total_cnt++;
      if (bar_height !== 6'(e)) $display("FAIL clamp_bar sel=%0d got=%0d required=%0d", s, bar_height, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_overrun();
    int n, bc, dc, late_busy;
    ema_alpha = 2'd0;
    for (int i = 0; i < 101; i++) bins_m[i] = 20;
    apply_bins();
    do_reset();
    n = 0; bc = 0; dc = 0; late_busy = 0;
    vsync = 1'b1;
    while (dc == 0 && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 3) vsync = 1'b0;
      if (busy) bc++;
      if (bc == 50) vsync = 1'b1;
      if (bc == 52) vsync = 1'b0;
      if (frame_done) dc++;
    end
    vsync = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (frame_done) dc++;
      if (busy) late_busy++;
    end
    total_cnt++;
    if (overrun !== 1'b1) $display("FAIL overrun_flag got=%b required=1", overrun);
    else pass_cnt++;
    total_cnt++;
    if (dc !== 1 || late_busy !== 0)
      $display("FAIL overrun_single done_pulses=%0d late_busy=%0d required 1 and 0", dc, late_busy);
    else pass_cnt++;
    for (int s = 0; s < 16; s++) begin
      bar_sel = 5'(s);
      #1;
      total_cnt++;
      if (bar_height !== 6'd20) $display("FAIL overrun_bar sel=%0d got=%0d required=20", s, bar_height);
      else pass_cnt++;
    end
  endtask

  task automatic test_peak();
    int bc, lat, dc;
    bit to;
    ema_alpha = 2'd0;
    for (int i = 0; i < 101; i++) bins_m[i] = 25;
    apply_bins();
    do_reset();
    for (int f = 0; f < 13; f++) begin
      run_walk(bc, lat, dc, to);
      model_frame(0);
      for (int i = 0; i < 101; i++) bins_m[i] = 0;
      apply_bins();
      for (int s = 0; s < 16; s += 3) begin
        bar_sel = 5'(s);
        #1;
        total_cnt++;
        if (bar_height !== 6'(m_disp[s]) || peak_height !== 6'(exp_peak(s)))
          $display("FAIL peak_frame%0d sel=%0d bar=%0d peak=%0d required %0d and %0d", f + 1, s,
                   bar_height, peak_height, m_disp[s], exp_peak(s));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_random();
    int bc, lat, dc;
    bit to;
    int a;
    do_reset();
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 101; i++) bins_m[i] = (f % 3 == 2) ? 50 + $urandom_range(0, 13)
                                                             : $urandom_range(0, 63);
      apply_bins();
      a = $urandom_range(0, 3);
      ema_alpha = 2'(a);
      run_walk(bc, lat, dc, to);
      model_frame(a);
      total_cnt++;
      if (to || dc !== 1 || bc !== 115)
        $display("FAIL random_walk%0d done_pulses=%0d busy=%0d required 1 and 115", f, dc, bc);
      else pass_cnt++;
      for (int s = 0; s < 17; s++) begin
        bar_sel = 5'(s);
        #1;
        total_cnt++;
        if (bar_height !== 6'((s < 16) ? m_disp[s] : 0) || peak_height !== 6'(exp_peak(s)))
          $display("FAIL random_frame%0d sel=%0d bar=%0d peak=%0d required %0d and %0d", f, s,
                   bar_height, peak_height, (s < 16) ? m_disp[s] : 0, exp_peak(s));
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; ema_alpha = '0; bar_sel = '0; freq_scaled = '0;
    test_reset();
    test_flat();
    test_ema();
    test_clamp();
    test_overrun();
    test_peak();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
